// File: rtl/memory_if.sv
// Data-bus handshake between the memory pipeline stage and the data memory.
// The stage is the master; the memory (or bus model) is the slave.
interface memory_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/memory.sv
// Memory pipeline stage: registers execute-stage results, runs the data-bus
// request FSM and selects the writeback value.
module memory (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write_e,
    input  logic        rd_write_e,
    input  logic        mem_write_e,
    input  logic [1:0]  rd_write_src_e,
    input  logic [4:0]  rd_e,
    input  logic [31:0] pc_e,
    input  logic [31:0] alu_res_e,
    input  logic [31:0] mem_data_e,
    input  logic        stall_m,
    input  logic        flush_m,
    output logic        pc_write_m,
    output logic        rd_write_m,
    output logic [1:0]  rd_write_src_m,
    output logic [4:0]  rd_m,
    output logic [31:0] pc_m,
    output logic [31:0] alu_res_m,
    output logic [31:0] result_m,
    output logic        busy_m,
    memory_if.master    dmem
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACCESS = 2'b01;
    localparam logic [1:0] DONE   = 2'b10;

    logic [1:0]  state;
    logic        mem_write_m;
    logic [31:0] mem_data_m;
    logic [31:0] mem_rdata_m;
    logic        mem_op_e;
    logic        bus_done;

    assign mem_op_e = mem_write_e || (rd_write_e && (rd_write_src_e == 2'b01));
    assign bus_done = (state == ACCESS) && dmem.dmem_ready;
    assign busy_m   = (state == ACCESS) && !dmem.dmem_ready;

    // Bus fields come straight from held pipeline registers, so they stay
    // stable for as long as the slave keeps the request waiting.
    assign dmem.dmem_req   = (state == ACCESS);
    assign dmem.dmem_we    = mem_write_m;
    assign dmem.dmem_addr  = alu_res_m;
    assign dmem.dmem_wdata = mem_data_m;

    // Pipeline registers and FSM; a waiting request outranks flush and stall
    // so an outstanding bus transaction is never abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc_write_m     <= 1'b0;
            rd_write_m     <= 1'b0;
            mem_write_m    <= 1'b0;
            rd_write_src_m <= 2'b00;
            rd_m           <= 5'd0;
            pc_m           <= 32'd0;
            alu_res_m      <= 32'd0;
            mem_data_m     <= 32'd0;
            mem_rdata_m    <= 32'd0;
        end else begin
            if (bus_done) begin
                mem_rdata_m <= dmem.dmem_rdata;
            end
            if (busy_m) begin
                state <= state;
            end else if (flush_m) begin
                state          <= IDLE;
                pc_write_m     <= 1'b0;
                rd_write_m     <= 1'b0;
                mem_write_m    <= 1'b0;
                rd_write_src_m <= 2'b00;
                rd_m           <= 5'd0;
                pc_m           <= 32'd0;
                alu_res_m      <= 32'd0;
                mem_data_m     <= 32'd0;
            end else if (stall_m) begin
                if (bus_done) begin
                    state <= DONE;
                end
            end else begin
                state          <= mem_op_e ? ACCESS : IDLE;
                pc_write_m     <= pc_write_e;
                rd_write_m     <= rd_write_e;
                mem_write_m    <= mem_write_e;
                rd_write_src_m <= rd_write_src_e;
                rd_m           <= rd_e;
                pc_m           <= pc_e;
                alu_res_m      <= alu_res_e;
                mem_data_m     <= mem_data_e;
            end
        end
    end

    // Load data bypasses the capture register during the completing cycle.
    always_comb begin
        result_m = alu_res_m;
        case (rd_write_src_m)
            2'b01:   result_m = (state == ACCESS) ? dmem.dmem_rdata : mem_rdata_m;
            2'b10:   result_m = pc_m + 32'd4;
            default: result_m = alu_res_m;
        endcase
    end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset: clk, rst_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 pc_write_e, rd_write_e, mem_write_e  in  1 each  execute-stage control bits.
REQ-005 rd_write_src_e  in  2  writeback source: 00 ALU, 01 load data, 10 PC+4, 11 ALU.
REQ-006 rd_e  in  5  destination register.
REQ-007 pc_e, alu_res_e, mem_data_e  in  32 each  PC, ALU result / address, store data.
REQ-008 stall_m, flush_m  in  1 each  hazard-unit hold and bubble requests.
REQ-009 pc_write_m, rd_write_m  out  1 each  registered control.
REQ-010 rd_write_src_m  out  2  registered writeback source.
REQ-011 rd_m  out  5  registered destination.
REQ-012 pc_m, alu_res_m  out  32 each  registered PC and ALU result; alu_res_m is also the forwarding source.
REQ-013 result_m  out  32  combinational writeback value.
REQ-014 busy_m  out  1  memory-wait stall request to the hazard unit.
REQ-015 dmem_req, dmem_we  out  1 each  data-bus request and write enable.
REQ-016 dmem_addr, dmem_wdata  out  32 each  bus address and write data.
REQ-017 dmem_ready  in  1  bus completion, sampled only while dmem_req=1.
REQ-018 dmem_rdata  in  32  load data, valid when dmem_ready=1.

Function
REQ-019 Memory op: mem_write_m=1, or rd_write_src_m=01 with rd_write_m=1.
REQ-020 FSM states: IDLE, ACCESS, DONE.
REQ-021 dmem_req=1 exactly when state=ACCESS.
REQ-022 dmem_we=mem_write_m, dmem_addr=alu_res_m, dmem_wdata=mem_data_m (registered store data).
REQ-023 busy_m = (state==ACCESS) && !dmem_ready.
REQ-024 Per-edge priority: busy_m=1 -> hold everything; else flush_m=1 -> clear all pipeline registers, state IDLE; else stall_m=1 -> hold pipeline registers; else load all *_e inputs.
REQ-025 Next state on load: ACCESS if the loaded instruction is a memory op, else IDLE.
REQ-026 Next state without load: ACCESS with dmem_ready -> DONE; otherwise hold.
REQ-027 On every edge with state=ACCESS and dmem_ready=1, capture dmem_rdata into mem_rdata_m, regardless of load, stall or flush.
REQ-028 While dmem_req=1 and dmem_ready=0, dmem_we, dmem_addr and dmem_wdata SHALL remain stable.
REQ-029 flush_m and stall_m SHALL NOT abort an outstanding request.
REQ-030 result_m selection:
- 00/11: alu_res_m.
- 01: dmem_rdata when state=ACCESS, else mem_rdata_m.
- 10: pc_m+4, modulo 2^32.
REQ-031 Zero-wait bus (dmem_ready=1 in the first ACCESS cycle): busy_m stays 0 and the op occupies the stage for one cycle.
REQ-032 Back-to-back memory ops: each op's load passes directly ACCESS->ACCESS, with a fresh request for the new op.
REQ-033 All outputs except result_m, busy_m and the dmem_* signals SHALL be registered.

Reset
REQ-034 rst_n=0 SHALL immediately clear all pipeline registers and mem_rdata_m to 0 and set state to IDLE.
REQ-035 Consequently, during and after reset until the first load: dmem_req=0, busy_m=0, result_m=0.
REQ-036 Reset asserted mid-ACCESS SHALL drop dmem_req asynchronously; the bus side SHALL tolerate the abandoned transaction.

Verification
REQ-037 ALU op: alu_res_e=0x10, rd_write_src_e=00, rd_write_e=1, rd_e=5 -> next cycle rd_m=5, result_m=0x10, dmem_req=0.
REQ-038 Zero-wait load: alu_res_e=0x100, src=01, dmem_ready=1, dmem_rdata=0xDEADBEEF -> one cycle with dmem_req=1 and busy_m=0, result_m=0xDEADBEEF.
REQ-039 Load with 3 wait cycles -> busy_m=1 for 3 cycles with dmem_addr held at 0x100; data captured; then state advances.
REQ-040 Store: mem_data_e=0xCAFE0001, alu_res_e=0x20 -> dmem_we=1, dmem_wdata=0xCAFE0001; with stall_m=1 afterwards -> state DONE and no second request.
REQ-041 flush_m=1 during a wait -> flush deferred until dmem_ready=1; next edge clears rd_write_m=0 and sets state IDLE.
REQ-042 JAL-type: pc_e=0xFFFFFFFC, src=10 -> result_m=0x00000000; reset asserted mid-ACCESS -> dmem_req=0 immediately.
